// File: rtl/aurora_pkt_tester.sv
// Aurora AXI-stream traffic generator with a free-running loopback checker on the RX side.
// Define AURORA_PKT_TESTER_ERRINJ_EN to add the err_inj input (flips bit 0 of the next accepted TX beat).
module aurora_pkt_tester #(
    parameter int BYTES    = 16,
    parameter int PACK_LEN = 16,
    parameter int PACK_GAP = 0,
    parameter int PACK_NUM = 0
) (
    input  logic                 user_clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic                 stop,
    input  logic                 channel_up,
`ifdef AURORA_PKT_TESTER_ERRINJ_EN
    input  logic                 err_inj,
`endif
    output logic [8*BYTES-1:0]   tx_tdata,
    output logic [BYTES-1:0]     tx_tkeep,
    output logic                 tx_tvalid,
    output logic                 tx_tlast,
    input  logic                 tx_tready,
    input  logic [8*BYTES-1:0]   rx_tdata,
    input  logic [BYTES-1:0]     rx_tkeep,
    input  logic                 rx_tvalid,
    input  logic                 rx_tlast,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          tx_cnt,
    output logic [31:0]          rx_cnt,
    output logic [15:0]          err_cnt
);
    typedef enum logic [1:0] {IDLE, SEND, GAP, FINISH} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  rst_sync_reg;
    logic [31:0] pkt_idx_reg;
    logic [8:0]  beat_idx_reg;
    logic [7:0]  gap_cnt_reg;
    logic        stop_pend_reg;
    logic [31:0] tx_cnt_reg;
    logic [31:0] rx_cnt_reg;
    logic [15:0] err_cnt_reg;
    logic [7:0]  rx_pkt_idx_reg;
    logic [8:0]  rx_beat_idx_reg;
    logic        inj_bit;

    logic               start_ok, tx_fire, last_beat, pkt_done, run_over;
    logic [7:0]         tx_byte, rx_byte;
    logic [8*BYTES-1:0] tx_word, rx_word;
    logic               rx_exp_last, rx_err;

    // Start is only honoured once the synchronised reset release has propagated.
    assign start_ok  = start && channel_up && rst_sync_reg[1] && (state_reg == IDLE);
    assign tx_fire   = tx_tvalid && tx_tready;
    assign last_beat = (beat_idx_reg == 9'(PACK_LEN - 1));
    assign pkt_done  = tx_fire && last_beat;
    assign run_over  = stop || stop_pend_reg ||
                       ((PACK_NUM != 0) && (pkt_idx_reg + 32'd1 == 32'(PACK_NUM)));

    assign tx_byte     = pkt_idx_reg[7:0] + beat_idx_reg[7:0];
    assign rx_byte     = rx_pkt_idx_reg + rx_beat_idx_reg[7:0];
    assign rx_exp_last = (rx_beat_idx_reg == 9'(PACK_LEN - 1));

    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign tx_word[8*gi +: 8] = tx_byte;
        assign rx_word[8*gi +: 8] = rx_byte;
    end

    assign rx_err = (rx_tdata != rx_word) || (rx_tkeep != '1) || (rx_tlast != rx_exp_last);

    // TX outputs decode straight from the state register so reset clears them asynchronously.
    assign tx_tvalid = (state_reg == SEND);
    assign tx_tkeep  = {BYTES{tx_tvalid}};
    assign tx_tlast  = tx_tvalid && last_beat;
    assign tx_tdata  = tx_tvalid ? (tx_word ^ {{(8*BYTES-1){1'b0}}, inj_bit}) : '0;
    assign busy      = (state_reg != IDLE);
    assign done      = (state_reg == FINISH);
    assign tx_cnt    = tx_cnt_reg;
    assign rx_cnt    = rx_cnt_reg;
    assign err_cnt   = err_cnt_reg;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start_ok) state_next = SEND;
            end
            SEND: begin
                if (!channel_up) begin
                    state_next = FINISH;
                end else if (pkt_done) begin
                    if (run_over)          state_next = FINISH;
                    else if (PACK_GAP > 0) state_next = GAP;
                    else                   state_next = SEND;
                end
            end
            GAP: begin
                if (!channel_up || stop || stop_pend_reg) state_next = FINISH;
                else if (gap_cnt_reg == 8'(PACK_GAP - 1)) state_next = SEND;
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Generator datapath.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_reg  <= 2'b00;
            pkt_idx_reg   <= '0;
            beat_idx_reg  <= '0;
            gap_cnt_reg   <= '0;
            stop_pend_reg <= 1'b0;
            tx_cnt_reg    <= '0;
        end else begin
            rst_sync_reg <= {rst_sync_reg[0], 1'b1};
            if (start_ok) begin
                pkt_idx_reg   <= '0;
                beat_idx_reg  <= '0;
                gap_cnt_reg   <= '0;
                stop_pend_reg <= 1'b0;
                tx_cnt_reg    <= '0;
            end else begin
                if (tx_fire) begin
                    if (last_beat) begin
                        beat_idx_reg <= '0;
                        pkt_idx_reg  <= pkt_idx_reg + 32'd1;
                        if (tx_cnt_reg != '1) tx_cnt_reg <= tx_cnt_reg + 32'd1;
                    end else begin
                        beat_idx_reg <= beat_idx_reg + 9'd1;
                    end
                end
                gap_cnt_reg <= (state_reg == GAP) ? gap_cnt_reg + 8'd1 : 8'd0;
                if (busy && stop)            stop_pend_reg <= 1'b1;
                else if (state_reg == IDLE)  stop_pend_reg <= 1'b0;
            end
        end
    end

`ifdef AURORA_PKT_TESTER_ERRINJ_EN
    logic inj_pend_reg;

    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n)     inj_pend_reg <= 1'b0;
        else if (err_inj) inj_pend_reg <= 1'b1;
        else if (tx_fire) inj_pend_reg <= 1'b0;
    end
    assign inj_bit = inj_pend_reg;
`else
    assign inj_bit = 1'b0;
`endif

    // Checker: any tlast re-aligns to beat 0 of the next packet, whatever was expected.
    always_ff @(posedge user_clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_pkt_idx_reg  <= '0;
            rx_beat_idx_reg <= '0;
            rx_cnt_reg      <= '0;
            err_cnt_reg     <= '0;
        end else if (start_ok) begin
            rx_pkt_idx_reg  <= '0;
            rx_beat_idx_reg <= '0;
            rx_cnt_reg      <= '0;
            err_cnt_reg     <= '0;
        end else begin
            if (rx_tvalid) begin
                if (rx_err && (err_cnt_reg != '1)) err_cnt_reg <= err_cnt_reg + 16'd1;
                if (rx_tlast) begin
                    rx_beat_idx_reg <= '0;
                    rx_pkt_idx_reg  <= rx_pkt_idx_reg + 8'd1;
                    if (rx_cnt_reg != '1) rx_cnt_reg <= rx_cnt_reg + 32'd1;
                end else begin
                    rx_beat_idx_reg <= rx_beat_idx_reg + 9'd1;
                end
            end
            if (!channel_up) rx_beat_idx_reg <= '0;
        end
    end
endmodule

// File: tb/tb_aurora_pkt_tester.sv
// Directed loopback bench for aurora_pkt_tester: full runs, stalls, stop, link drop, reset abort, gaps.
`timescale 1ns/1ps
module tb_aurora_pkt_tester;
    localparam int LEN = 16;

    logic user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    logic         reset_n, start, stop, channel_up;
    logic         toggle_mode, tog_reg = 1'b0;
    logic         tx_tready;
    logic [127:0] tx_tdata;
    logic [15:0]  tx_tkeep;
    logic         tx_tvalid, tx_tlast, busy, done;
    logic [31:0]  tx_cnt, rx_cnt;
    logic [15:0]  err_cnt;
`ifdef AURORA_PKT_TESTER_ERRINJ_EN
    logic         err_inj;
`endif

    logic         start_b;
    logic [31:0]  b_tdata;
    logic [3:0]   b_tkeep;
    logic         b_tvalid, b_tlast, b_busy, b_done;
    logic [31:0]  b_tx_cnt, b_rx_cnt;
    logic [15:0]  b_err_cnt;

    always @(posedge user_clk) tog_reg <= ~tog_reg;
    assign tx_tready = toggle_mode ? tog_reg : 1'b1;

    aurora_pkt_tester #(.BYTES(16), .PACK_LEN(LEN), .PACK_GAP(0), .PACK_NUM(4)) dut (
        .user_clk(user_clk), .reset_n(reset_n), .start(start), .stop(stop), .channel_up(channel_up),
`ifdef AURORA_PKT_TESTER_ERRINJ_EN
        .err_inj(err_inj),
`endif
        .tx_tdata(tx_tdata), .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast),
        .tx_tready(tx_tready),
        .rx_tdata(tx_tdata), .rx_tkeep(tx_tkeep), .rx_tvalid(tx_tvalid && tx_tready), .rx_tlast(tx_tlast),
        .busy(busy), .done(done), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .err_cnt(err_cnt)
    );

    aurora_pkt_tester #(.BYTES(4), .PACK_LEN(4), .PACK_GAP(3), .PACK_NUM(2)) dut_gap (
        .user_clk(user_clk), .reset_n(reset_n), .start(start_b), .stop(1'b0), .channel_up(channel_up),
`ifdef AURORA_PKT_TESTER_ERRINJ_EN
        .err_inj(1'b0),
`endif
        .tx_tdata(b_tdata), .tx_tkeep(b_tkeep), .tx_tvalid(b_tvalid), .tx_tlast(b_tlast),
        .tx_tready(1'b1),
        .rx_tdata(b_tdata), .rx_tkeep(b_tkeep), .rx_tvalid(b_tvalid), .rx_tlast(b_tlast),
        .busy(b_busy), .done(b_done), .tx_cnt(b_tx_cnt), .rx_cnt(b_rx_cnt), .err_cnt(b_err_cnt)
    );

    int total = 0;
    int bad = 0;
    int m_pkt = 0, m_beat = 0, beats_a = 0, done_a = 0;
    int b_gap = 0, b_gaps_seen = 0;
    bit b_in_gap = 1'b0;
    bit skip_data;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] exp_word(input int p, input int b);
        logic [7:0] v;
        v = 8'(p + b);
        return {16{v}};
    endfunction

    // Reference model of the TX stream; it only advances on an accepted beat, so a stalled beat
    // is compared against the same expected word on every cycle it is held.
    always @(negedge user_clk) begin
        if (start && channel_up && !busy) begin
            m_pkt  = 0;
            m_beat = 0;
        end
        if (done) done_a++;
        if (tx_tvalid) begin
            if (!skip_data) check("tdata", tx_tdata, exp_word(m_pkt, m_beat));
            check("tlast", 128'(tx_tlast), 128'(m_beat == LEN - 1));
            check("tkeep", 128'(tx_tkeep), 128'hFFFF);
            if (tx_tready) begin
                beats_a++;
                if (m_beat == LEN - 1) begin
                    m_beat = 0;
                    m_pkt++;
                end else begin
                    m_beat++;
                end
            end
        end
    end

    always @(negedge user_clk) begin
        if (b_tvalid) begin
            if (b_in_gap) begin
                check("gap_len", 128'(b_gap), 128'd3);
                b_gaps_seen++;
                b_in_gap = 1'b0;
            end
            if (b_tlast) begin
                b_in_gap = 1'b1;
                b_gap = 0;
            end
        end else if (b_in_gap) begin
            b_gap++;
        end
    end

    task automatic pulse_start();
        @(posedge user_clk); #1;
        start = 1'b1;
        @(posedge user_clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 600 && !done; i++) @(negedge user_clk);
        check({tag, "_done_seen"}, 128'(done), 128'd1);
        repeat (2) @(negedge user_clk);
    endtask

    task automatic run_full(input string tag);
        int b0, d0;
        b0 = beats_a;
        d0 = done_a;
        pulse_start();
        wait_done(tag);
        check({tag, "_beats"}, 128'(beats_a - b0), 128'd64);
        check({tag, "_done_pulses"}, 128'(done_a - d0), 128'd1);
        check({tag, "_tx_cnt"}, 128'(tx_cnt), 128'd4);
        check({tag, "_rx_cnt"}, 128'(rx_cnt), 128'd4);
        check({tag, "_err_cnt"}, 128'(err_cnt), 128'd0);
        check({tag, "_busy"}, 128'(busy), 128'd0);
        $display("run %s: tx_cnt=%0d rx_cnt=%0d err_cnt=%0d", tag, tx_cnt, rx_cnt, err_cnt);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; start = 1'b0; stop = 1'b0; channel_up = 1'b1;
        start_b = 1'b0; toggle_mode = 1'b0; skip_data = 1'b0;
`ifdef AURORA_PKT_TESTER_ERRINJ_EN
        err_inj = 1'b0;
`endif
        repeat (3) @(posedge user_clk); #1;
        check("rst_tvalid", 128'(tx_tvalid), 128'd0);
        check("rst_tdata", tx_tdata, 128'd0);
        check("rst_busy", 128'(busy), 128'd0);
        check("rst_done", 128'(done), 128'd0);
        check("rst_tx_cnt", 128'(tx_cnt), 128'd0);
        check("rst_err_cnt", 128'(err_cnt), 128'd0);

        // start presented on the first edge after release is too early
        reset_n = 1'b1;
        start = 1'b1;
        @(posedge user_clk); #1;
        start = 1'b0;
        repeat (3) @(posedge user_clk); #1;
        check("early_start_busy", 128'(busy), 128'd0);

        channel_up = 1'b0;
        pulse_start();
        repeat (3) @(posedge user_clk); #1;
        check("nolink_start_busy", 128'(busy), 128'd0);
        channel_up = 1'b1;

        run_full("basic");

        toggle_mode = 1'b1;
        run_full("stall");
        toggle_mode = 1'b0;

        // stop lands in packet 1, which must still complete
        pulse_start();
        repeat (20) @(posedge user_clk); #1;
        stop = 1'b1;
        @(posedge user_clk); #1;
        stop = 1'b0;
        wait_done("stop");
        check("stop_tx_cnt", 128'(tx_cnt), 128'd2);
        check("stop_rx_cnt", 128'(rx_cnt), 128'd2);
        check("stop_err_cnt", 128'(err_cnt), 128'd0);
        $display("run stop: tx_cnt=%0d rx_cnt=%0d err_cnt=%0d", tx_cnt, rx_cnt, err_cnt);

        // link drop while beat 7 of packet 2 is on the bus
        pulse_start();
        for (int i = 0; i < 200 && !(m_pkt == 2 && m_beat == 7); i++) begin
            @(posedge user_clk); #1;
        end
        check("drop_reached_beat7", 128'(m_pkt == 2 && m_beat == 7), 128'd1);
        channel_up = 1'b0;
        @(posedge user_clk); #1;
        check("drop_tvalid", 128'(tx_tvalid), 128'd0);
        check("drop_done", 128'(done), 128'd1);
        check("drop_tx_cnt", 128'(tx_cnt), 128'd2);
        check("drop_rx_cnt", 128'(rx_cnt), 128'd2);
        check("drop_err_cnt", 128'(err_cnt), 128'd0);
        $display("run drop: tx_cnt=%0d rx_cnt=%0d err_cnt=%0d", tx_cnt, rx_cnt, err_cnt);
        repeat (3) @(posedge user_clk); #1;
        channel_up = 1'b1;
        run_full("relink");

        // reset in the middle of packet 1
        pulse_start();
        repeat (25) @(posedge user_clk); #1;
        check("pre_rst_tx_cnt", 128'(tx_cnt), 128'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_tvalid", 128'(tx_tvalid), 128'd0);
        check("midrst_tdata", tx_tdata, 128'd0);
        check("midrst_tlast", 128'(tx_tlast), 128'd0);
        check("midrst_busy", 128'(busy), 128'd0);
        check("midrst_tx_cnt", 128'(tx_cnt), 128'd0);
        check("midrst_rx_cnt", 128'(rx_cnt), 128'd0);
        repeat (2) @(posedge user_clk); #1;
        check("midrst_hold_tvalid", 128'(tx_tvalid), 128'd0);
        reset_n = 1'b1;
        repeat (3) @(posedge user_clk); #1;
        run_full("after_rst");

`ifdef AURORA_PKT_TESTER_ERRINJ_EN
        skip_data = 1'b1;
        pulse_start();
        repeat (20) @(posedge user_clk); #1;
        err_inj = 1'b1;
        @(posedge user_clk); #1;
        err_inj = 1'b0;
        wait_done("errinj");
        check("errinj_err_cnt", 128'(err_cnt), 128'd1);
        check("errinj_rx_cnt", 128'(rx_cnt), 128'd4);
        $display("run errinj: tx_cnt=%0d rx_cnt=%0d err_cnt=%0d", tx_cnt, rx_cnt, err_cnt);
        skip_data = 1'b0;
`endif

        @(posedge user_clk); #1;
        start_b = 1'b1;
        @(posedge user_clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < 200 && !b_done; i++) @(negedge user_clk);
        check("gap_done_seen", 128'(b_done), 128'd1);
        repeat (2) @(negedge user_clk);
        check("gap_tx_cnt", 128'(b_tx_cnt), 128'd2);
        check("gap_rx_cnt", 128'(b_rx_cnt), 128'd2);
        check("gap_err_cnt", 128'(b_err_cnt), 128'd0);
        check("gap_count", 128'(b_gaps_seen), 128'd1);
        $display("run gap: tx_cnt=%0d rx_cnt=%0d err_cnt=%0d gaps=%0d", b_tx_cnt, b_rx_cnt, b_err_cnt, b_gaps_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
